// File: rtl/ucode_loader_if.sv
// Byte-stream input and control-store write bus of the microcode loader.
interface ucode_loader_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int WORD_WIDTH = 41
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;

    // master: stream source / store observer; slave: the loader
    modport master (output in_data, in_valid,
                    input  in_ready, wr_en, wr_addr, wr_data);
    modport slave  (input  in_data, in_valid,
                    output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/ucode_loader.sv
// Packs a checksummed byte stream into microwords, writes them to the control
// store at ascending addresses and releases the sequencer once the image checks.
module ucode_loader #(
    parameter int CONTROL_WIDTH = 27,
    parameter int ADDR_WIDTH    = 13,
    parameter int WORD_COUNT    = 8192
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    ucode_loader_if.slave   bus,
    output logic            seq_hold,
    output logic            done,
    output logic            error
);
    localparam int WORD_WIDTH     = CONTROL_WIDTH + ADDR_WIDTH + 1;
    localparam int BYTES_PER_WORD = (WORD_WIDTH + 7) / 8;
    localparam int BUF_W          = BYTES_PER_WORD * 8;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD + 1);

    localparam logic [BUF_W-1:0]      PAD_MASK  = {BUF_W{1'b1}} << WORD_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);
    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t                state, next_state;
    logic [BUF_W-1:0]      word_buf;
    logic [CNT_W-1:0]      byte_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            csum;
    logic                  in_ready;
    logic                  wr_en;
    logic                  accept;
    logic                  pad_bad;

    assign accept  = bus.in_valid & in_ready;
    assign pad_bad = |(word_buf & PAD_MASK);

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = addr;
    assign bus.wr_data  = word_buf[WORD_WIDTH-1:0];

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  next_state = IDLE;
            LOAD:  if (accept && byte_cnt == LAST_BYTE) next_state = WRITE;
            WRITE: begin
                if (pad_bad)                next_state = ERROR;
                else if (addr == LAST_ADDR) next_state = CHECK;
                else                        next_state = LOAD;
            end
            CHECK: if (accept) next_state = (bus.in_data == csum) ? DONE : ERROR;
            DONE:  next_state = DONE;
            ERROR: next_state = ERROR;
            default: next_state = IDLE;
        endcase
        // A restart overrides everything; the current WRITE cycle, if any, still strobes.
        if (start) next_state = LOAD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            seq_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == LOAD) || (next_state == CHECK);
            wr_en    <= (next_state == WRITE);
            seq_hold <= (next_state != DONE);
            done     <= (next_state == DONE);
            error    <= (next_state == ERROR);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_buf <= '0;
            byte_cnt <= '0;
            addr     <= '0;
            csum     <= '0;
        end else if (start) begin
            byte_cnt <= '0;
            addr     <= '0;
            csum     <= '0;
        end else begin
            unique case (state)
                LOAD: if (accept) begin
                    // Little-endian packing: byte k lands in bits [8k+7:8k].
                    for (int k = 0; k < BYTES_PER_WORD; k++) begin
                        if (byte_cnt == CNT_W'(k)) word_buf[k*8 +: 8] <= bus.in_data;
                    end
                    csum     <= csum ^ bus.in_data;
                    byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + CNT_W'(1);
                end
                WRITE: if (next_state == LOAD) addr <= addr + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ucode_loader.sv
// Directed bench for ucode_loader with a 4-word image.
module tb_ucode_loader;
    localparam int CW = 27;
    localparam int AW = 13;
    localparam int WW = CW + AW + 1;
    localparam int WC = 4;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic seq_hold, done, error;

    ucode_loader_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    ucode_loader #(.CONTROL_WIDTH(CW), .ADDR_WIDTH(AW), .WORD_COUNT(WC)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .seq_hold (seq_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_vec_t;

    typedef struct {
        bit         gap;
        logic [7:0] csum;
        bit         exp_done;
        bit         exp_err;
    } run_vec_t;

    int total = 0;
    int bad   = 0;

    logic [7:0]    img [24];
    wr_vec_t       exp_wr [WC];
    run_vec_t      runs [3];
    logic [AW-1:0] cap_addr [16];
    logic [WW-1:0] cap_data [16];
    int            ncap = 0;

    always @(negedge clock) begin
        if (bus.wr_en === 1'b1) begin
            if (ncap < 16) begin
                cap_addr[ncap] = bus.wr_addr;
                cap_data[ncap] = bus.wr_data;
            end
            ncap = ncap + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (bus.in_ready === 1'b1) begin
                @(posedge clock);
                ok = 1'b1;
                break;
            end
        end
        #1 bus.in_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_byte_timeout: byte %0h accepted=0 required=1", b);
        end
        if (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, 64'(ncap), 64'(WC));
        for (int i = 0; i < WC; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(cap_addr[i]), 64'(exp_wr[i].addr));
            chk($sformatf("%s_data%0d", tag, i), 64'(cap_data[i]), 64'(exp_wr[i].data));
        end
    endtask

    task automatic run_image(input string tag, input run_vec_t rv);
        pulse_start();
        ncap = 0;
        for (int i = 0; i < 24; i++) send_byte(img[i], rv.gap);
        send_byte(rv.csum, 1'b0);
        repeat (2) @(negedge clock);
        check_writes(tag);
        chk({tag, "_done"},     64'(done),        64'(rv.exp_done));
        chk({tag, "_error"},    64'(error),       64'(rv.exp_err));
        chk({tag, "_seq_hold"}, 64'(seq_hold),    64'(!rv.exp_done));
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    endtask

    initial begin
        // Image 0x01..0x18 with the last byte of each word masked to bit 0.
        for (int i = 0; i < 24; i++) img[i] = 8'(i + 1);
        img[5] = 8'h00; img[11] = 8'h00; img[17] = 8'h00; img[23] = 8'h00;
        exp_wr[0] = '{13'd0, 41'h00_0504030201};
        exp_wr[1] = '{13'd1, 41'h00_0B0A090807};
        exp_wr[2] = '{13'd2, 41'h00_11100F0E0D};
        exp_wr[3] = '{13'd3, 41'h00_1716151413};
        runs[0] = '{1'b0, 8'h18, 1'b1, 1'b0};
        runs[1] = '{1'b0, 8'h00, 1'b0, 1'b1};
        runs[2] = '{1'b1, 8'h18, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_seq_hold", 64'(seq_hold),     64'(1));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_wr_en",    64'(bus.wr_en),    64'(0));
        chk("rst_wr_addr",  64'(bus.wr_addr),  64'(0));
        chk("rst_wr_data",  64'(bus.wr_data),  64'(0));
        chk("rst_done",     64'(done),         64'(0));
        chk("rst_error",    64'(error),        64'(0));
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        for (int r = 0; r < 3; r++) run_image($sformatf("run%0d", r), runs[r]);

        // Pad bit set in the last byte of word 1.
        pulse_start();
        ncap = 0;
        for (int i = 0; i < 12; i++) send_byte((i == 11) ? 8'h02 : img[i], 1'b0);
        repeat (3) @(negedge clock);
        chk("pad_wr_count", 64'(ncap),        64'(2));
        chk("pad_addr1",    64'(cap_addr[1]), 64'(1));
        chk("pad_data1",    64'(cap_data[1]), 64'(41'h00_0B0A090807));
        chk("pad_error",    64'(error),       64'(1));
        chk("pad_seq_hold", 64'(seq_hold),    64'(1));
        chk("pad_done",     64'(done),        64'(0));

        // Abort after 10 garbage bytes, then load the valid image.
        pulse_start();
        ncap = 0;
        for (int i = 0; i < 10; i++) send_byte((i == 5) ? 8'h01 : 8'h55, 1'b0);
        @(negedge clock);
        chk("abort_old_writes", 64'(ncap), 64'(1));
        #1;
        run_image("restart", runs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: finished=0 required=1");
        $fatal(1, "timeout");
    end
endmodule
